// File: rtl/bit_to_stream.sv
// Bit-serial to word deserializer with valid/ready on both sides and a single output holding register.
// Define BIT_TO_STREAM_LSB_FIRST_EN to pack least significant bit first (default: MSB first).
module bit_to_stream #(
  parameter int WIDTH = 32
) (
  input  logic             clk_gen,
  input  logic             rstn,
  input  logic             align,
  input  logic             bits_in_tvalid,
  output logic             bits_in_tready,
  input  logic             bits_in_tdata,
  output logic             words_out_tvalid,
  input  logic             words_out_tready,
  output logic [WIDTH-1:0] words_out_tdata
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-2:0] sr;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;

  logic             last_bit;
  logic             bit_beat;
  logic             word_beat;
  logic [WIDTH-1:0] packed_word;
  logic [WIDTH-2:0] sr_next;

  assign last_bit  = (cnt == CNT_LAST);
  assign bits_in_tready = rstn & ~align & (~last_bit | ~out_valid | words_out_tready);
  assign bit_beat  = bits_in_tvalid & bits_in_tready;
  assign word_beat = out_valid & words_out_tready;

  // packed_word doubles as the shifted register image, so WIDTH=2 needs no special slicing.
`ifdef BIT_TO_STREAM_LSB_FIRST_EN
  assign packed_word = {bits_in_tdata, sr};
  assign sr_next     = packed_word[WIDTH-1:1];
`else
  assign packed_word = {sr, bits_in_tdata};
  assign sr_next     = packed_word[WIDTH-2:0];
`endif

  always_ff @(posedge clk_gen) begin
    if (!rstn) begin
      sr        <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (align) begin
        sr  <= '0;
        cnt <= '0;
      end else if (bit_beat) begin
        if (last_bit) begin
          cnt <= '0;
        end else begin
          sr  <= sr_next;
          cnt <= cnt + 1'b1;
        end
      end

      // A completing word in the same cycle as a word beat simply replaces the held one.
      if (bit_beat && last_bit) begin
        out_data  <= packed_word;
        out_valid <= 1'b1;
      end else if (word_beat) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign words_out_tvalid = out_valid;
  assign words_out_tdata  = out_data;

endmodule

// File: tb/tb_bit_to_stream.sv
// Self-checking bench for bit_to_stream: word-level model, delivery scoreboard and directed vectors.
// Honours BIT_TO_STREAM_LSB_FIRST_EN for the send order, matching the design build.
module tb_bit_to_stream;
  localparam int W = 32;

  logic         clk_gen = 1'b0;
  logic         rstn;
  logic         align;
  logic         bits_in_tvalid;
  logic         bits_in_tready;
  logic         bits_in_tdata;
  logic         words_out_tvalid;
  logic         words_out_tready;
  logic [W-1:0] words_out_tdata;

  bit_to_stream #(.WIDTH(W)) dut (
    .clk_gen          (clk_gen),
    .rstn             (rstn),
    .align            (align),
    .bits_in_tvalid   (bits_in_tvalid),
    .bits_in_tready   (bits_in_tready),
    .bits_in_tdata    (bits_in_tdata),
    .words_out_tvalid (words_out_tvalid),
    .words_out_tready (words_out_tready),
    .words_out_tdata  (words_out_tdata)
  );

  always #5 clk_gen = ~clk_gen;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_cnt = 0;
  bit started = 1'b0;

  logic [W-1:0] exp_q[$];
  int           beat_cyc[$];

  // model: bits gathered so far, and the word held for the consumer
  int           m_cnt = 0;
  logic [W-1:0] m_acc = '0;
  logic [W-1:0] m_data = '0;
  logic         m_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic bit_at(input logic [W-1:0] w, input int k);
`ifdef BIT_TO_STREAM_LSB_FIRST_EN
    return w[k];
`else
    return w[W-1-k];
`endif
  endfunction

  always @(posedge clk_gen) begin
    logic rdy;
    logic wbeat;
    if (!rstn) begin
      m_cnt = 0; m_acc = '0; m_data = '0; m_valid = 1'b0;
    end else begin
      rdy   = !align && (m_cnt != W-1 || !m_valid || words_out_tready);
      wbeat = m_valid && words_out_tready;
      if (wbeat) m_valid = 1'b0;
      if (align) begin
        m_cnt = 0; m_acc = '0;
      end else if (bits_in_tvalid && rdy) begin
`ifdef BIT_TO_STREAM_LSB_FIRST_EN
        m_acc[m_cnt] = bits_in_tdata;
`else
        m_acc = {m_acc[W-2:0], bits_in_tdata};
`endif
        if (m_cnt == W-1) begin
          m_data = m_acc; m_valid = 1'b1; m_cnt = 0; m_acc = '0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  always @(negedge clk_gen) begin
    logic rdy_exp;
    cyc++;
    if (started) begin
      rdy_exp = rstn && !align && (m_cnt != W-1 || !m_valid || words_out_tready);
      chk("tready", 32'(bits_in_tready), 32'(rdy_exp));
      chk("tvalid", 32'(words_out_tvalid), 32'(m_valid));
      chk("tdata", words_out_tdata, m_data);
      if (words_out_tvalid && words_out_tready) begin
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) fail_now("unexpected_word");
        else chk("word_order", words_out_tdata, exp_q.pop_front());
      end
    end
  end

  task automatic send_bit(input logic b);
    int t = 0;
    logic acc;
    bits_in_tvalid = 1'b1;
    bits_in_tdata  = b;
    do begin
      @(negedge clk_gen);
      acc = bits_in_tready;
      @(posedge clk_gen);
      #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) fail_now("bit_accept_timeout");
    stall_cnt += t - 1;
    bits_in_tvalid = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int n);
    for (int k = 0; k < n; k++) send_bit(bit_at(w, k));
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || words_out_tvalid) && t < 300) begin
      @(posedge clk_gen);
      #1;
      t++;
    end
    if (t >= 300) fail_now("drain_timeout");
  endtask

  initial begin
    rstn = 1'b0; align = 1'b0; bits_in_tvalid = 1'b0; bits_in_tdata = 1'b0;
    words_out_tready = 1'b0;
    @(posedge clk_gen);
    started = 1'b1;
    @(posedge clk_gen);
    @(negedge clk_gen);
    chk("reset_tvalid", 32'(words_out_tvalid), 32'h0);
    chk("reset_tdata", words_out_tdata, 32'h0);
    chk("reset_tready", 32'(bits_in_tready), 32'h0);
    @(posedge clk_gen); #1 rstn = 1'b1;

    // single word, latency
    words_out_tready = 1'b1;
    exp_q.push_back(32'hA5A5A5A5);
    send_word(32'hA5A5A5A5, W-1);
    bits_in_tvalid = 1'b1; bits_in_tdata = bit_at(32'hA5A5A5A5, W-1);
    @(negedge clk_gen);
    chk("t1_tvalid_at_last_bit", 32'(words_out_tvalid), 32'h0);
    @(posedge clk_gen); #1 bits_in_tvalid = 1'b0;
    @(negedge clk_gen);
    chk("t1_tvalid_after", 32'(words_out_tvalid), 32'h1);
    chk("t1_word", words_out_tdata, 32'hA5A5A5A5);
    drain();

    // backpressure at the word-completing bit
    words_out_tready = 1'b0;
    exp_q.push_back(32'hCCCCCCCC);
    exp_q.push_back(32'hDDDDDDDD);
    send_word(32'hCCCCCCCC, W);
    send_word(32'hDDDDDDDD, W-1);
    bits_in_tvalid = 1'b1; bits_in_tdata = bit_at(32'hDDDDDDDD, W-1);
    repeat (3) begin
      @(negedge clk_gen);
      chk("t2_stall_tready", 32'(bits_in_tready), 32'h0);
      chk("t2_hold_word", words_out_tdata, 32'hCCCCCCCC);
    end
    @(posedge clk_gen); #1 words_out_tready = 1'b1;
    @(negedge clk_gen);
    chk("t2_resume_tready", 32'(bits_in_tready), 32'h1);
    @(posedge clk_gen); #1 bits_in_tvalid = 1'b0;
    @(negedge clk_gen);
    chk("t2_second_word", words_out_tdata, 32'hDDDDDDDD);
    drain();

    // align discards a partial word
    send_word(32'hDEADBEEF, 10);
    align = 1'b1; bits_in_tvalid = 1'b1; bits_in_tdata = 1'b1;
    @(negedge clk_gen);
    chk("t3_align_tready", 32'(bits_in_tready), 32'h0);
    @(posedge clk_gen); #1 align = 1'b0; bits_in_tvalid = 1'b0;
    exp_q.push_back(32'h12345678);
    send_word(32'h12345678, W);
    @(negedge clk_gen);
    chk("t3_word", words_out_tdata, 32'h12345678);
    drain();

    // reset drops both held and partial words
    words_out_tready = 1'b0;
    send_word(32'h11111111, W);
    send_word(32'h22222222, 20);
    rstn = 1'b0;
    @(posedge clk_gen);
    @(negedge clk_gen);
    chk("t4_reset_tvalid", 32'(words_out_tvalid), 32'h0);
    chk("t4_reset_tdata", words_out_tdata, 32'h0);
    chk("t4_reset_tready", 32'(bits_in_tready), 32'h0);
    @(posedge clk_gen); #1 rstn = 1'b1; words_out_tready = 1'b1;
    exp_q.push_back(32'h0F0F0F0F);
    send_word(32'h0F0F0F0F, W);
    drain();

    // back-to-back throughput
    beat_cyc.delete();
    stall_cnt = 0;
    exp_q.push_back(32'h00000001);
    exp_q.push_back(32'h80000000);
    exp_q.push_back(32'hFFFFFFFF);
    send_word(32'h00000001, W);
    send_word(32'h80000000, W);
    send_word(32'hFFFFFFFF, W);
    drain();
    chk("t5_no_bubbles", 32'(stall_cnt), 32'h0);
    chk("t5_word_count", 32'(beat_cyc.size()), 32'd3);
    if (beat_cyc.size() == 3) begin
      chk("t5_gap01", 32'(beat_cyc[1] - beat_cyc[0]), 32'd32);
      chk("t5_gap12", 32'(beat_cyc[2] - beat_cyc[1]), 32'd32);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
